// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the decoupled instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int PERF_W      = 32;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect/halt control and decode handshake.
interface fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req_valid;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, halt,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, halt,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush, registered count and full/empty flags.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int W     = 24,
  localparam int CW    = occ_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~full & ~flush;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Decoupled instruction fetch: credit-limited imem requests, in-order response queue, redirect with kill.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed / perf_stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 16,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  fetch_if.master           bus
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_flushed,
  output logic [PERF_W-1:0] perf_stall
`endif
);
  localparam int CW = occ_w(DEPTH);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP   = PC_W'(PC_STEP);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fpc, rsp_pc;
  logic [CW-1:0]   outstanding, kill_cnt, fifo_count;
  logic [CW:0]     occ_after_pop;
  logic            pop, req_fire, rsp_acc, drop, push, q_full, q_empty;
  entry_t          q_din, q_head;

  assign pop = bus.if_valid & bus.if_ready;

  // A slot freed by this cycle's pop may be re-used by this cycle's request.
  assign occ_after_pop = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);

  assign bus.imem_req_valid = ~bus.halt & ~bus.redirect_valid &
                              (occ_after_pop < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fpc;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  // Responses with nothing outstanding are stragglers from before a reset.
  assign rsp_acc  = bus.imem_rsp_valid & (outstanding != '0);
  assign drop     = rsp_acc & (bus.redirect_valid | (kill_cnt != '0));
  assign push     = rsp_acc & ~drop;

  assign q_din = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  fetch_queue #(.DEPTH(DEPTH), .W(PC_W + INSTR_W)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_head),
    .count (fifo_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.if_valid = ~q_empty;
  assign bus.if_instr = q_head.instr;
  assign bus.if_pc    = q_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RST_PC;
      rsp_pc      <= RST_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_acc);
      if (bus.redirect_valid) begin
        fpc      <= bus.redirect_pc;
        rsp_pc   <= bus.redirect_pc;
        // No request fires in a redirect cycle, so every survivor is stale.
        kill_cnt <= outstanding - CW'(rsp_acc);
      end else begin
        if (req_fire) fpc      <= fpc + STEP;
        if (push)     rsp_pc   <= rsp_pc + STEP;
        if (drop)     kill_cnt <= kill_cnt - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + PERF_W'(1);
      perf_flushed <= perf_flushed + PERF_W'(drop) +
                      (bus.redirect_valid ? PERF_W'(fifo_count) : PERF_W'(0));
      if (bus.if_ready & ~bus.if_valid) perf_stall <= perf_stall + PERF_W'(1);
    end
  end
`endif

  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && q_full));
  a_no_stray_rsp : assert property (@(posedge clk) disable iff (rst)
                                    bus.imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1- or 2-cycle in-order instruction memory model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.PC_W(8), .INSTR_W(16)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  fetch_stage #(
    .PC_W(8), .INSTR_W(16), .DEPTH(2), .RESET_PC(0), .PC_STEP(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall)
`endif
  );

  // Memory returns {~addr, addr} after 1 cycle, or 2 cycles when lat2 is set.
  bit          lat2 = 1'b0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [15:0] s1_d = '0, s2_d = '0;
  always @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= bus.imem_req_valid & bus.imem_req_ready;
      s1_d <= {~bus.imem_req_addr, bus.imem_req_addr};
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign bus.imem_rsp_valid = lat2 ? s2_v : s1_v;
  assign bus.imem_rsp_data  = lat2 ? s2_d : s1_d;

  int           nreq = 0;
  fetch_entry_t cap[$];
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.imem_req_valid && bus.imem_req_ready) nreq <= nreq + 1;
      if (bus.if_valid && bus.if_ready) cap.push_back('{pc: bus.if_pc, instr: bus.if_instr});
    end
  end

  int total = 0;
  int bad   = 0;
  int n0, c0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic fetch_entry_t pick(input int i);
    fetch_entry_t e;
    e = '1;
    if (i < cap.size()) e = cap[i];
    return e;
  endfunction

  task automatic do_reset(input bit l2);
    @(negedge clk);
    rst = 1'b1;
    lat2 = l2;
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    bus.if_ready       = 1'b1;

    // streaming with 1-cycle memory
    do_reset(1'b0);
    #1;
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_req_valid", bus.imem_req_valid, 1);
    chk("rst_addr", bus.imem_req_addr, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("seq_addr", bus.imem_req_addr, k);
      if (k >= 2) begin
        chk("seq_valid", bus.if_valid, 1);
        chk("seq_pc", bus.if_pc, k - 2);
      end else begin
        chk("seq_empty", bus.if_valid, 0);
      end
    end
    chk("seq_instr", bus.if_instr, 16'hFC03);

    // decode back-pressure fills exactly DEPTH credits
    do_reset(1'b0);
    bus.if_ready = 1'b0;
    n0 = nreq;
    repeat (10) @(negedge clk);
    chk("hold_nreq", nreq - n0, 2);
    chk("hold_valid", bus.if_valid, 1);
    chk("hold_pc", bus.if_pc, 8'h00);
    chk("hold_noreq", bus.imem_req_valid, 0);
    c0 = cap.size();
    bus.if_ready = 1'b1;
    #1;
    chk("rel_req_valid", bus.imem_req_valid, 1);
    chk("rel_addr", bus.imem_req_addr, 8'h02);
    repeat (4) @(negedge clk);
    chk("rel_pc0", pick(c0).pc, 8'h00);
    chk("rel_pc1", pick(c0 + 1).pc, 8'h01);
    chk("rel_instr1", pick(c0 + 1).instr, 16'hFE01);
    chk("rel_pc2", pick(c0 + 2).pc, 8'h02);
    chk("rel_pc3", pick(c0 + 3).pc, 8'h03);

    // redirect with one outstanding and one buffered entry
    do_reset(1'b0);
    bus.if_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_redir_pc", bus.if_pc, 8'h00);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    #1;
    chk("redir_noreq", bus.imem_req_valid, 0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b1;
    #1;
    c0 = cap.size();
    chk("redir_flushed", bus.if_valid, 0);
    chk("redir_req_valid", bus.imem_req_valid, 1);
    chk("redir_addr", bus.imem_req_addr, 8'h40);
    @(negedge clk);
    chk("redir_r2_empty", bus.if_valid, 0);
    @(negedge clk);
    chk("redir_r3_valid", bus.if_valid, 1);
    chk("redir_r3_pc", bus.if_pc, 8'h40);
    chk("redir_r3_instr", bus.if_instr, 16'hBF40);
    @(negedge clk);
    chk("redir_r4_pc", bus.if_pc, 8'h41);
    chk("redir_first_pop", pick(c0).pc, 8'h40);

    // 2-cycle memory: kill of a stale response, plus PC wrap
    do_reset(1'b1);
    bus.if_ready = 1'b0;
    repeat (2) @(negedge clk);
    c0 = cap.size();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFE;
    bus.if_ready       = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("wrap_count", (cap.size() >= c0 + 3), 1);
    chk("wrap_pc0", pick(c0).pc, 8'hFE);
    chk("wrap_instr0", pick(c0).instr, 16'h01FE);
    chk("wrap_pc1", pick(c0 + 1).pc, 8'hFF);
    chk("wrap_instr1", pick(c0 + 1).instr, 16'h00FF);
    chk("wrap_pc2", pick(c0 + 2).pc, 8'h00);
    chk("wrap_instr2", pick(c0 + 2).instr, 16'hFF00);
`ifdef FETCH_PERF_EN
    chk("perf_flushed", perf_flushed, 2);
    chk("perf_fetched", perf_fetched, cap.size() - c0);
`endif

    // memory stall then halt mid-stream
    do_reset(1'b0);
    bus.if_ready       = 1'b1;
    bus.imem_req_ready = 1'b0;
    n0 = nreq;
    c0 = cap.size();
    #1;
    chk("stall_addr0", bus.imem_req_addr, 8'h00);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("stall_req_valid", bus.imem_req_valid, 1);
      chk("stall_addr", bus.imem_req_addr, 8'h00);
    end
    chk("stall_nreq", nreq - n0, 0);
    bus.imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.halt = 1'b1;
    #1;
    chk("halt_noreq", bus.imem_req_valid, 0);
    repeat (6) @(negedge clk);
    chk("halt_nreq", nreq - n0, 3);
    chk("halt_drained", bus.if_valid, 0);
    chk("halt_pops", cap.size() - c0, 3);
    chk("halt_last_pc", pick(c0 + 2).pc, 8'h02);
    bus.halt = 1'b0;
    #1;
    chk("unhalt_req", bus.imem_req_valid, 1);
    chk("unhalt_addr", bus.imem_req_addr, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
